// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder_pkg : shared state encoding and address slicing   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package data_mem_responder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam int CNT_W  = 4;
  localparam int IDX_LO = 2;

  // Top bit of the word-index slice taken from a byte address.
  function automatic int idx_hi(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_array : sync-write, registered-read word array with sync clear   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_array #(
  parameter int data_width = 32,
  parameter int addr_width = 8,
  parameter int test_width = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic                  rd_en_i,
  input  logic                  rd_zero_i,
  input  logic [addr_width-1:0] idx_i,
  input  logic [data_width-1:0] wdata_i,
  output logic [data_width-1:0] rdata_o,
  output logic [test_width-1:0] word0_o
);

  localparam int c_depth = 2 ** addr_width;

  logic [data_width-1:0] mem_q [c_depth];
  logic [data_width-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < c_depth; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (wr_en_i) begin
        mem_q[idx_i] <= wdata_i;
      end
      if (rd_zero_i) begin
        rdata_q <= '0;
      end else if (rd_en_i) begin
        rdata_q <= mem_q[idx_i];
      end
    end
  end

  assign rdata_o = rdata_q;
  assign word0_o = mem_q[0][test_width-1:0];

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | data_mem_responder : wait-state data-memory responder (load/store)   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int data_width  = 32,
  parameter int addr_width  = 8,
  parameter int wait_cycles = 2,
  parameter int test_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  mem_write,
  input  logic [data_width-1:0] addr,
  input  logic [data_width-1:0] write_data,
  output logic [data_width-1:0] read_data,
  output logic                  ready,
  output logic                  busy,
  output logic                  align_err,
  output logic [test_width-1:0] test_value
);

  localparam int               c_idx_hi = idx_hi(addr_width);
  localparam logic [CNT_W-1:0] c_wait   = CNT_W'(wait_cycles);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [addr_width-1:0] idx_q;
  logic [1:0]            ofs_q;
  logic [data_width-1:0] wdata_q;
  logic                  we_q;
  logic                  ready_q;
  logic                  align_err_q;

  logic w_accept;
  logic w_access;
  logic w_aligned;

  // Address bits above the word index wrap away by design.
  generate
    if (data_width > c_idx_hi + 1) begin : g_unused_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^addr[data_width-1:c_idx_hi+1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      ready_q     <= 1'b0;
      align_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ready_q     <= w_access;
      align_err_q <= w_access & ~w_aligned;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      idx_q   <= '0;
      ofs_q   <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
    end else if (w_accept) begin
      idx_q   <= addr[c_idx_hi:IDX_LO];
      ofs_q   <= addr[1:0];
      wdata_q <= write_data;
      we_q    <= mem_write;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_accept = 1'b0;
    w_access = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          w_accept = 1'b1;
          cnt_d    = c_wait;
          state_d  = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          w_access = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign w_aligned = (ofs_q == 2'b00);

  dmem_array #(
    .data_width(data_width),
    .addr_width(addr_width),
    .test_width(test_width)
  ) u_array (
    .clk      (clk),
    .reset    (reset),
    .wr_en_i  (w_access & we_q & w_aligned),
    .rd_en_i  (w_access & ~we_q & w_aligned),
    .rd_zero_i(w_access & ~w_aligned),
    .idx_i    (idx_q),
    .wdata_i  (wdata_q),
    .rdata_o  (read_data),
    .word0_o  (test_value)
  );

  assign ready     = ready_q;
  assign align_err = align_err_q;
  assign busy      = (state_q == ST_BUSY);

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_data_mem_responder : two responders (2 and 0 wait states) vs model |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        req;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] write_data;

  logic [31:0] rd0, rd1;
  logic        rdy0, rdy1, bsy0, bsy1, aerr0, aerr1;
  logic [15:0] tv0, tv1;

  int vectors     = 0;
  int miscompares = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  data_mem_responder #(.data_width(32), .addr_width(8), .wait_cycles(2), .test_width(16)) u_dut0 (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(rd0), .ready(rdy0), .busy(bsy0),
    .align_err(aerr0), .test_value(tv0)
  );

  data_mem_responder #(.data_width(32), .addr_width(8), .wait_cycles(0), .test_width(16)) u_dut1 (
    .clk(clk), .reset(reset), .req(req), .mem_write(mem_write), .addr(addr),
    .write_data(write_data), .read_data(rd1), .ready(rdy1), .busy(bsy1),
    .align_err(aerr1), .test_value(tv1)
  );

  // Transaction-level model: an access accepted at edge n completes at edge n+W+1.
  int          m_wait [2] = '{2, 0};
  logic [31:0] m_mem  [2][256];
  bit          m_act  [2];
  bit          m_we   [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wd   [2];
  logic [31:0] m_rd   [2];
  bit          m_rdy  [2];
  bit          m_aerr [2];
  longint      m_done [2];
  longint      cyc = 0;

  always @(posedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!reset) begin
        for (int j = 0; j < 256; j++) m_mem[k][j] = 32'h0;
        m_act[k] = 0; m_rdy[k] = 0; m_aerr[k] = 0; m_rd[k] = 32'h0;
      end else begin
        m_rdy[k]  = 0;
        m_aerr[k] = 0;
        if (m_act[k] && cyc == m_done[k]) begin
          m_act[k] = 0;
          m_rdy[k] = 1;
          if (m_addr[k] % 4 != 0) begin
            m_rd[k]   = 32'h0;
            m_aerr[k] = 1;
          end else if (m_we[k]) begin
            m_mem[k][(m_addr[k] / 4) % 256] = m_wd[k];
          end else begin
            m_rd[k] = m_mem[k][(m_addr[k] / 4) % 256];
          end
        end else if (!m_act[k] && req) begin
          m_act[k]  = 1;
          m_we[k]   = mem_write;
          m_addr[k] = addr;
          m_wd[k]   = write_data;
          m_done[k] = cyc + m_wait[k] + 1;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dut0.ready",      {31'b0, rdy0},  {31'b0, m_rdy[0]});
      chk("dut0.busy",       {31'b0, bsy0},  {31'b0, m_act[0]});
      chk("dut0.align_err",  {31'b0, aerr0}, {31'b0, m_aerr[0]});
      chk("dut0.read_data",  rd0,            m_rd[0]);
      chk("dut0.test_value", {16'b0, tv0},   {16'b0, m_mem[0][0][15:0]});
      chk("dut1.ready",      {31'b0, rdy1},  {31'b0, m_rdy[1]});
      chk("dut1.busy",       {31'b0, bsy1},  {31'b0, m_act[1]});
      chk("dut1.align_err",  {31'b0, aerr1}, {31'b0, m_aerr[1]});
      chk("dut1.read_data",  rd1,            m_rd[1]);
      chk("dut1.test_value", {16'b0, tv1},   {16'b0, m_mem[1][0][15:0]});
    end
  end

  // One request pulse; waits (bounded) for dut0's ready and reports latency and busy cycles.
  task automatic do_access(input bit we, input logic [31:0] a, input logic [31:0] d,
                           output int lat, output int bcnt);
    @(negedge clk);
    req = 1'b1; mem_write = we; addr = a; write_data = d;
    @(negedge clk);
    req  = 1'b0;
    lat  = 0;
    bcnt = bsy0 ? 1 : 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bsy0) bcnt++;
      if (rdy0) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL access_timeout: got no ready, expected ready within 20 cycles");
    end
  endtask

  initial begin
    int lat, bcnt;
    logic [6:0] pat;

    reset = 1'b0; req = 1'b0; mem_write = 1'b0; addr = '0; write_data = '0;
    repeat (2) @(negedge clk);
    reset  = 1'b1;
    chk_en = 1'b1;
    chk("reset.busy",       {31'b0, bsy0}, 32'h0);
    chk("reset.test_value", {16'b0, tv0},  32'h0);

    do_access(1'b1, 32'h0, 32'h0000ABCD, lat, bcnt);
    chk("store0.latency",    lat,          32'd3);
    chk("store0.busy_cycles", bcnt,        32'd3);
    @(negedge clk);
    chk("store0.test_value", {16'b0, tv0}, 32'h0000ABCD);

    do_access(1'b1, 32'h10, 32'hDEADBEEF, lat, bcnt);
    do_access(1'b0, 32'h10, 32'h0, lat, bcnt);
    chk("load10.read_data", rd0,            32'hDEADBEEF);
    chk("load10.align_err", {31'b0, aerr0}, 32'h0);

    do_access(1'b0, 32'h13, 32'h0, lat, bcnt);
    chk("load13.read_data", rd0,            32'h0);
    chk("load13.align_err", {31'b0, aerr0}, 32'h1);
    do_access(1'b0, 32'h10, 32'h0, lat, bcnt);
    chk("reload10.read_data", rd0, 32'hDEADBEEF);

    do_access(1'b1, 32'h400, 32'h5, lat, bcnt);
    do_access(1'b0, 32'h0, 32'h0, lat, bcnt);
    chk("wrap.read_data",  rd0,           32'h5);
    chk("wrap.test_value", {16'b0, tv0},  32'h5);

    // Back-to-back stores, address stepping every cycle.
    pat = '0;
    @(negedge clk);
    req = 1'b1; mem_write = 1'b1; addr = 32'h40; write_data = 32'h1000;
    for (int i = 0; i <= 6; i++) begin
      @(negedge clk);
      pat[i] = rdy1;
      if (i + 1 <= 4) begin
        addr       = 32'h40 + 4 * (i + 1);
        write_data = 32'h1000 + (i + 1);
      end else begin
        req = 1'b0;
      end
    end
    chk("b2b.ready_pattern", {25'b0, pat}, 32'h0000002A);
    repeat (8) @(negedge clk);
    do_access(1'b0, 32'h44, 32'h0, lat, bcnt);
    chk("b2b.dut1_ignored", rd1, 32'h0);
    do_access(1'b0, 32'h48, 32'h0, lat, bcnt);
    chk("b2b.dut1_word48", rd1, 32'h00001002);
    chk("b2b.dut0_word48", rd0, 32'h0);

    // Reset while dut0 is busy with a store.
    @(negedge clk);
    req = 1'b1; mem_write = 1'b1; addr = 32'h20; write_data = 32'h77;
    @(negedge clk);
    req = 1'b0;
    chk("midrst.busy_before", {31'b0, bsy0}, 32'h1);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst.busy_after", {31'b0, bsy0}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("midrst.no_ready", {31'b0, rdy0}, 32'h0);
    end
    do_access(1'b0, 32'h20, 32'h0, lat, bcnt);
    chk("midrst.load20", rd0, 32'h0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 49) != 0);
      req        = ($urandom_range(0, 9) < 6);
      mem_write  = $urandom_range(0, 1);
      write_data = $urandom;
      case ($urandom_range(0, 3))
        0:       addr = $urandom;
        1:       addr = $urandom_range(0, 15) * 4;
        2:       addr = $urandom_range(0, 63);
        default: addr = 32'h400 + $urandom_range(0, 7) * 4;
      endcase
    end
    @(negedge clk);
    reset = 1'b1; req = 1'b0;
    repeat (12) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
